// File: rtl/nbit_down_counter_if.sv
// Control/status bundle for the N-bit loadable down counter.
// master drives load/clear/enable; slave returns count/busy/done.
interface nbit_down_counter_if #(
  parameter int N = 6
);
  logic         load;
  logic [N-1:0] load_value;
  logic         clear;
  logic         enable;
  logic         auto_reload;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  modport master (
    output load,
    output load_value,
    output clear,
    output enable,
    output auto_reload,
    input  count,
    input  busy,
    input  done
  );

  modport slave (
    input  load,
    input  load_value,
    input  clear,
    input  enable,
    input  auto_reload,
    output count,
    output busy,
    output done
  );
endinterface

// File: rtl/nbit_down_counter.sv
// N-bit loadable down counter/timer with one-shot or periodic reload.
// Optional decrement prescaler enabled by DOWN_COUNTER_PRESCALE_EN.
module nbit_down_counter #(
  parameter int N        = 6,
  parameter int PRESCALE = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  nbit_down_counter_if.slave     bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  if (N < 2) begin : g_bad_n
    $error("nbit_down_counter: N must be >= 2");
  end
  if (PRESCALE < 2) begin : g_bad_pre
    $error("nbit_down_counter: PRESCALE must be >= 2");
  end

  logic [0:0]   r_state;
  logic [N-1:0] r_count;
  logic [N-1:0] r_reload;
  logic         r_done;

  logic [0:0]   w_state_nx;
  logic [N-1:0] w_count_nx;
  logic [N-1:0] w_reload_nx;
  logic         w_done_nx;

  logic w_run;
  logic w_tick;
  logic w_step;
  logic w_at_one;
  logic w_lv_zero;

  // Mutually exclusive action selects encode clear > load > step > hold.
  logic w_do_clr;
  logic w_do_ld;
  logic w_do_ld0;
  logic w_do_term;
  logic w_do_dec;

  assign w_run     = (r_state == S_RUN);
  assign w_at_one  = (r_count == N'(1));
  assign w_lv_zero = (bus.load_value == '0);

`ifdef DOWN_COUNTER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;

  assign w_tick = (r_pre == PRE_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (bus.clear || bus.load) begin
      r_pre <= '0;
    end else if (w_run && bus.enable) begin
      if (w_tick) r_pre <= '0;
      else        r_pre <= r_pre + PW'(1);
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  assign w_step    = w_run && bus.enable && w_tick;
  assign w_do_clr  = bus.clear;
  assign w_do_ld   = !bus.clear && bus.load && !w_lv_zero;
  assign w_do_ld0  = !bus.clear && bus.load && w_lv_zero;
  assign w_do_term = !bus.clear && !bus.load && w_step && w_at_one;
  assign w_do_dec  = !bus.clear && !bus.load && w_step && !w_at_one;

  always_comb begin
    w_state_nx  = r_state;
    w_count_nx  = r_count;
    w_reload_nx = r_reload;
    w_done_nx   = 1'b0;
    unique case (1'b1)
      w_do_clr: begin
        w_count_nx = '0;
        w_state_nx = S_IDLE;
      end
      w_do_ld: begin
        w_count_nx  = bus.load_value;
        w_reload_nx = bus.load_value;
        w_state_nx  = S_RUN;
      end
      w_do_ld0: begin
        w_count_nx = '0;
        w_state_nx = S_IDLE;
      end
      w_do_term: begin
        w_done_nx = 1'b1;
        // Periodic mode skips the 1->0 step so the period is exactly L.
        if (bus.auto_reload) begin
          w_count_nx = r_reload;
        end else begin
          w_count_nx = '0;
          w_state_nx = S_IDLE;
        end
      end
      w_do_dec: begin
        w_count_nx = r_count - N'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_count  <= w_count_nx;
      r_reload <= w_reload_nx;
      r_done   <= w_done_nx;
    end
  end

  assign bus.count = r_count;
  assign bus.busy  = w_run;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_nbit_down_counter.sv
// Directed bench for nbit_down_counter at N=6, N=4 and N=2.
// Expected values are hand-computed per step.
module tb_nbit_down_counter;

  logic clock;
  logic reset;

  int n_chk;
  int n_fail;

  nbit_down_counter_if #(.N(6)) ifa ();
  nbit_down_counter_if #(.N(4)) ifb ();
  nbit_down_counter_if #(.N(2)) ifc ();

  nbit_down_counter #(.N(6), .PRESCALE(4)) u_a (
    .clock (clock),
    .reset (reset),
    .bus   (ifa)
  );

  nbit_down_counter #(.N(4), .PRESCALE(4)) u_b (
    .clock (clock),
    .reset (reset),
    .bus   (ifb)
  );

  nbit_down_counter #(.N(2), .PRESCALE(4)) u_c (
    .clock (clock),
    .reset (reset),
    .bus   (ifc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int c,
                       input logic b, input logic d);
    chk({tag, ".count"}, 32'(ifa.count), 32'(c));
    chk({tag, ".busy"},  32'(ifa.busy),  32'(b));
    chk({tag, ".done"},  32'(ifa.done),  32'(d));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    ifa.load = 0; ifa.load_value = '0; ifa.clear = 0;
    ifa.enable = 0; ifa.auto_reload = 0;
    ifb.load = 0; ifb.load_value = '0; ifb.clear = 0;
    ifb.enable = 0; ifb.auto_reload = 0;
    ifc.load = 0; ifc.load_value = '0; ifc.clear = 0;
    ifc.enable = 0; ifc.auto_reload = 0;
    #1 reset = 1'b0;
    #1;
    chk_a("rst", 0, 0, 0);
    chk("rst.b", 32'(ifb.count), 0);
    chk("rst.c", 32'(ifc.count), 0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk_a("post_rst", 0, 0, 0);

`ifdef DOWN_COUNTER_PRESCALE_EN
    ifa.load = 1; ifa.load_value = 6'd2; ifa.enable = 1;
    tick();
    ifa.load = 0;
    chk_a("pre.ld", 2, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_a($sformatf("pre.e%0d", i),
            (i < 4) ? 2 : ((i < 8) ? 1 : 0),
            (i < 8), (i == 8));
    end
    ifa.load = 1;
    tick();
    ifa.load = 0;
    chk_a("pre.ld2", 2, 1, 0);
    tick();
    tick();
    ifa.enable = 0;
    repeat (3) tick();
    chk_a("pre.gap", 2, 1, 0);
    ifa.enable = 1;
    tick();
    tick();
    chk_a("pre.gap4", 1, 1, 0);
    repeat (4) tick();
    chk_a("pre.gap8", 0, 0, 1);
`else
    // One-shot from 5
    ifa.load = 1; ifa.load_value = 6'd5; ifa.enable = 1;
    tick();
    ifa.load = 0;
    chk_a("os.ld", 5, 1, 0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      chk_a($sformatf("os.c%0d", i), i, 1, 0);
    end
    tick();
    chk_a("os.term", 0, 0, 1);
    tick();
    chk_a("os.after", 0, 0, 0);

    // Asynchronous reset mid-run at count 3
    ifa.load = 1;
    tick();
    ifa.load = 0;
    tick();
    tick();
    chk_a("mid.pre", 3, 1, 0);
    #2 reset = 1'b0;
    #1;
    chk_a("mid.async", 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    chk_a("mid.idle", 0, 0, 0);

    // Auto-reload, N=4, load 3
    ifb.load = 1; ifb.load_value = 4'd3;
    ifb.auto_reload = 1; ifb.enable = 1;
    tick();
    ifb.load = 0;
    chk("ar.ld", 32'(ifb.count), 3);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("ar.c%0d", i), 32'(ifb.count),
          32'((i % 3 == 0) ? 2 : ((i % 3 == 1) ? 1 : 3)));
      chk($sformatf("ar.d%0d", i), 32'(ifb.done),
          32'(i % 3 == 2));
      chk($sformatf("ar.b%0d", i), 32'(ifb.busy), 1);
    end
    ifb.auto_reload = 0;
    tick();
    chk("ar.os1", 32'(ifb.count), 1);
    tick();
    chk("ar.os0", 32'(ifb.count), 0);
    chk("ar.osd", 32'(ifb.done), 1);
    chk("ar.osb", 32'(ifb.busy), 0);

    // Enable hold and restart
    ifa.load = 1; ifa.load_value = 6'd10;
    tick();
    ifa.load = 0;
    tick();
    tick();
    chk_a("en.8", 8, 1, 0);
    ifa.enable = 0;
    tick();
    chk_a("en.h1", 8, 1, 0);
    tick();
    chk_a("en.h2", 8, 1, 0);
    ifa.enable = 1;
    tick();
    tick();
    chk_a("en.6", 6, 1, 0);
    ifa.load = 1; ifa.load_value = 6'd4;
    tick();
    ifa.load = 0;
    chk_a("rl.4", 4, 1, 0);
    tick();
    chk_a("rl.3", 3, 1, 0);

    // clear beats load on the same edge
    ifa.clear = 1; ifa.load = 1; ifa.load_value = 6'd9;
    tick();
    ifa.clear = 0; ifa.load = 0;
    chk_a("clr.ld", 0, 0, 0);
    tick();
    chk_a("clr.hold", 0, 0, 0);

    // Load of zero aborts a run without done
    ifa.load = 1; ifa.load_value = 6'd7;
    tick();
    chk_a("z.ld7", 7, 1, 0);
    ifa.load_value = 6'd0;
    tick();
    ifa.load = 0;
    chk_a("z.ld0", 0, 0, 0);
    tick();
    chk_a("z.after", 0, 0, 0);

    // Load at count 1 discards the pending terminal count
    ifa.load = 1; ifa.load_value = 6'd2;
    tick();
    ifa.load = 0;
    tick();
    chk_a("pend.1", 1, 1, 0);
    ifa.load = 1; ifa.load_value = 6'd63;
    tick();
    ifa.load = 0;
    chk_a("pend.max", 63, 1, 0);
    tick();
    chk_a("pend.62", 62, 1, 0);

    // N=2 at maximum load
    ifc.load = 1; ifc.load_value = 2'd3; ifc.enable = 1;
    tick();
    ifc.load = 0;
    for (int i = 3; i >= 0; i--) begin
      chk($sformatf("n2.c%0d", i), 32'(ifc.count), 32'(i));
      chk($sformatf("n2.d%0d", i), 32'(ifc.done), 32'(i == 0));
      chk($sformatf("n2.b%0d", i), 32'(ifc.busy), 32'(i != 0));
      tick();
    end
    chk("n2.after", 32'(ifc.done), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nbit_down_counter.md
Name: nbit_down_counter

Overview:
- Parameterised N-bit loadable down counter/timer; the counting-down counterpart of the lab's N-bit up counter.
- Software or an FSM loads a start value, and the block decrements to a terminal count.
- At terminal count it raises a one-cycle done pulse and optionally reloads for periodic ticks.
- Used as a delay/timeout and tick generator next to the up counter in the lab designs.

Parameters:
- N, 6, counter width in bits (N >= 2).
- PRESCALE, 4, clock cycles per decrement; used only when DOWN_COUNTER_PRESCALE_EN is defined (PRESCALE >= 2).

Ports:
- clock  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- load  input  1  synchronous load strobe.
- load_value  input  N  start/reload value, sampled when load=1.
- clear  input  1  synchronous abort: count to 0, return to IDLE.
- enable  input  1  count enable; hold when 0.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode.
- count  output  N  current counter value (registered).
- busy  output  1  1 while in RUN state.
- done  output  1  one-cycle pulse at terminal count (registered).

Behaviour:
- Reset (reset=0, asynchronous):
  - count=0, done=0, busy=0, state=IDLE, internal reload register=0.
  - Takes effect immediately, including mid-run; counting resumes only after a new load.
- FSM states are IDLE and RUN; busy = (state==RUN), with no combinational path from inputs.
- Priority each edge: clear > load > decrement > hold.
- clear=1 (any state): count<=0, state<=IDLE, done<=0; a simultaneous load is ignored.
- load=1 with load_value!=0 (any state, clear=0):
  - count<=load_value, reload register<=load_value, state<=RUN, done<=0.
  - A load during RUN restarts the counter; a pending terminal count is discarded.
- load=1 with load_value==0: count<=0, state<=IDLE, no done pulse.
- RUN, enable=1, count>1: count<=count-1, done<=0.
- RUN, enable=1, count==1:
  - done<=1 for exactly one cycle.
  - auto_reload=0: count<=0, state<=IDLE.
  - auto_reload=1: count<=reload register (the 1→0 step is skipped), state stays RUN. Period is therefore exactly L enabled cycles for load value L.
- auto_reload is sampled at the count==1 edge only; changing it mid-run is legal.
- RUN, enable=0: count and state hold, done<=0.
- IDLE without load: count holds (0 after a one-shot finish), done<=0; enable has no effect.
- Timing: after load of L at edge t with enable held high, done=1 during the cycle after edge t+L, and count reads 0 (one-shot) from that edge on.
- Arithmetic: unsigned, modulo 2^N. Maximum load is 2^N-1. Decrement never underflows because 0 is never decremented.

Optional Feature:
- Macro: DOWN_COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler of width $clog2(PRESCALE) counts enabled RUN cycles.
  - The decrement/terminal rules above apply only on the cycle the prescaler reaches PRESCALE-1; it then wraps to 0.
  - The prescaler clears on reset, load and clear; it holds when enable=0 or in IDLE.
  - One-shot latency becomes L*PRESCALE enabled cycles.
- Not defined: no prescaler logic is generated; the block decrements every enabled RUN cycle, and PRESCALE is ignored.

Test Plan:
- Reset: reset=0 mid-run with count=3 → count=0, busy=0, done=0 immediately, without waiting for a clock edge. Release, then no change without load.
- One-shot, N=6: load 5, enable=1, auto_reload=0 → count 5,4,3,2,1,0; done=1 for one cycle with count=0; busy falls together with done; count stays 0 afterwards.
- Auto-reload, N=4: load 3, auto_reload=1, enable=1 → count 3,2,1,3,2,1,…; done pulses every 3 cycles; busy stays 1.
- Enable/hold and restart: load 10, enable toggled 0 for 2 cycles after count=8 → count holds 8. Load 4 while count=6 → next count 4, no done pulse.
- Priority/boundaries:
  - clear and load same edge → count=0, IDLE.
  - load_value=0 → count=0, busy=0, no done.
  - N=2, load 3 → 3,2,1,0 with done.
- With DOWN_COUNTER_PRESCALE_EN, PRESCALE=4: load 2, one-shot → count changes to 1 after 4 enabled cycles; done after 8; enable gaps stretch timing 1:1.
